ball_motion_engine: RTL and testbench
=====================================

BALL_MOTION_ENGINE -- requirements
Module: ball_motion_engine

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 4: number of balls; ball 0 is the cue ball.
REQ-002 SHALL have parameter FRAC_BITS, default 6: fixed-point fraction bits (1/64 pixel).
REQ-003 SHALL have parameters SPEED_STEP=200, MAX_SHOT_SPEED=1000, FRICTION=1, MIN_SPEED=2: speed/friction constants in fixed-point units per frame.
REQ-004 SHALL have parameters INIT_X0=100, INIT_Y0=220, INIT_DX=40, BALL_SIZE=32: ball i home position is (INIT_X0+i*INIT_DX, INIT_Y0), in pixels.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-008 chargeUp, chargeDown, chargeLeft, chargeRight  in  1 each  one-cycle shot-charge pulses.
REQ-009 releaseBall  in  1  one-cycle pulse that fires the charged shot.
REQ-010 collision  in  NUM_BALLS  per-ball collision strobe.
REQ-011 hitEdgeCode  in  4*NUM_BALLS  per-ball edge nibble, bits [3:0] = Left, Top, Right, Bottom.
REQ-012 pocketed  in  NUM_BALLS  per-ball pocket strobe.
REQ-013 topLeftX, topLeftY  out  11*NUM_BALLS each  signed pixel positions, ball i in slice [11i+10:11i].
REQ-014 ballActive  out  NUM_BALLS  1 = ball on table.
REQ-015 allStopped  out  1  all active balls have zero speed.
REQ-016 shotX, shotY  out  16 each  signed charged shot speed.
REQ-017 busy, frameOverrun  out  1 each  update in progress; startOfFrame arrived while busy (one-cycle pulse).

Function
REQ-018 Per ball SHALL hold signed 16-bit vx and vy, plus signed 11+FRAC_BITS-bit fixed-point px and py.
REQ-019 The FSM SHALL have states IDLE, UPDATE and DONE: IDLE->UPDATE on startOfFrame with idx=0; UPDATE processes ball idx in one cycle and idx increments; after idx=NUM_BALLS-1 the FSM moves to DONE; DONE->IDLE after one cycle.
REQ-020 busy SHALL be 1 in UPDATE and DONE, and an update SHALL finish NUM_BALLS+1 cycles after startOfFrame.
REQ-021 startOfFrame while busy SHALL be ignored and SHALL pulse frameOverrun for one cycle.
REQ-022 collision[i] with edge bit set SHALL set the matching pending flag (pendL, pendT, pendR, pendB) of ball i; the flag SHALL clear when ball i is updated, and a set in the same cycle SHALL win over the clear.
REQ-023 In UPDATE, reflection SHALL be: vx := -vx if (pendL && vx<0) or (pendR && vx>0); vy := -vy if (pendT && vy<0) or (pendB && vy>0).
REQ-024 Position SHALL then advance by the reflected speed: px += vx, py += vy.
REQ-025 If the new px or py leaves [0, (640-BALL_SIZE)<<FRAC_BITS] or [0, (480-BALL_SIZE)<<FRAC_BITS], that coordinate SHALL be clamped to the bound and its speed component negated.
REQ-026 Friction SHALL be applied per component after reflection: if |v| <= MIN_SPEED+FRICTION then v := 0, else v := v - sign(v)*FRICTION.
REQ-027 Inactive balls SHALL be skipped in UPDATE: idx still advances and their state is unchanged.
REQ-028 pocketed[i] for i>0 SHALL clear ballActive[i] and zero vx and vy next cycle; position SHALL hold.
REQ-029 pocketed[0] SHALL zero the cue speed and set a respawn flag; the next UPDATE of ball 0 SHALL load the home position with zero speed instead of REQ-023..026; ballActive[0] SHALL stay 1.
REQ-030 Charging SHALL act only when allStopped=1.
REQ-031 chargeLeft SHALL do shotX += SPEED_STEP, saturating at +MAX_SHOT_SPEED; chargeRight SHALL do shotX -= SPEED_STEP, saturating at -MAX_SHOT_SPEED. chargeUp and chargeDown SHALL act on shotY in the same way.
REQ-032 Opposing charge pulses in the same cycle SHALL leave the shot unchanged.
REQ-033 releaseBall with allStopped=1 and nonzero shot SHALL load vx0:=shotX and vy0:=shotY, clear shotX and shotY, and clear allStopped, all on the next cycle; otherwise releaseBall SHALL be ignored.
REQ-034 allStopped SHALL be recomputed in DONE as AND over active balls of (vx==0 && vy==0).
REQ-035 topLeftX and topLeftY SHALL be px and py arithmetically shifted right by FRAC_BITS (floor).
REQ-036 A release in the same cycle as an UPDATE of ball 0 SHALL take priority over that update's speed write.

Reset
REQ-037 reset SHALL force, at the next clk edge, even mid-update: FSM=IDLE, idx=0, all balls at home position with zero speed, ballActive all 1, all pending and respawn flags 0, shotX=shotY=0, allStopped=1, busy=0, frameOverrun=0.

Verification
REQ-038 Pulse chargeLeft 6 times -> shotX=200,400,...,1000, then stays 1000; chargeLeft+chargeRight in the same cycle -> unchanged.
REQ-039 Charge shotX=400, release, then startOfFrame -> after 5 cycles (NUM_BALLS=4): px0=6800, topLeftX ball0=106, vx0=399, allStopped=0.
REQ-040 vx0=-200 with collision[0] and hitEdgeCode[3]=1, then a frame -> vx0 becomes +200, px0 increases by 200, final vx0=199.
REQ-041 vx1=3, vy1=0, then a frame -> vx1=0; once the only moving ball stops -> allStopped=1 after DONE, and charging is accepted again.
REQ-042 pocketed[0] while the cue moves -> after the next frame ball 0 is at (100,220) with zero speed; pocketed[2] -> ballActive[2]=0 and ball 2 is frozen thereafter.
REQ-043 Assert reset during UPDATE with idx=2 -> next cycle busy=0 and all balls at home; startOfFrame while busy -> one frameOverrun pulse and no restart.

Source files
------------

// File: rtl/ball_motion_engine_if.sv
// Host-side bundle for the ball motion engine: frame/shot controls in, ball
// positions and status out. Per-ball fields are packed with ball 0 in the low slice.
interface ball_motion_engine_if #(
   parameter int NUM_BALLS = 4
);
   logic                       startOfFrame;
   logic                       chargeUp;
   logic                       chargeDown;
   logic                       chargeLeft;
   logic                       chargeRight;
   logic                       releaseBall;
   logic [NUM_BALLS-1:0]       collision;
   logic [4*NUM_BALLS-1:0]     hitEdgeCode;
   logic [NUM_BALLS-1:0]       pocketed;
   logic [11*NUM_BALLS-1:0]    topLeftX;
   logic [11*NUM_BALLS-1:0]    topLeftY;
   logic [NUM_BALLS-1:0]       ballActive;
   logic                       allStopped;
   logic signed [15:0]         shotX;
   logic signed [15:0]         shotY;
   logic                       busy;
   logic                       frameOverrun;

   modport master (
      output startOfFrame, chargeUp, chargeDown, chargeLeft, chargeRight,
             releaseBall, collision, hitEdgeCode, pocketed,
      input  topLeftX, topLeftY, ballActive, allStopped, shotX, shotY,
             busy, frameOverrun
   );

   modport slave (
      input  startOfFrame, chargeUp, chargeDown, chargeLeft, chargeRight,
             releaseBall, collision, hitEdgeCode, pocketed,
      output topLeftX, topLeftY, ballActive, allStopped, shotX, shotY,
             busy, frameOverrun
   );
endinterface

// File: rtl/ball_motion_engine.sv
// Per-frame ball kinematics: one ball per cycle gets edge reflection, position
// advance with wall clamping and friction; also handles cue shot charging and pockets.
module ball_motion_engine #(
   parameter int NUM_BALLS      = 4,
   parameter int FRAC_BITS      = 6,
   parameter int SPEED_STEP     = 200,
   parameter int MAX_SHOT_SPEED = 1000,
   parameter int FRICTION       = 1,
   parameter int MIN_SPEED      = 2,
   parameter int INIT_X0        = 100,
   parameter int INIT_Y0        = 220,
   parameter int INIT_DX        = 40,
   parameter int BALL_SIZE      = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   ball_motion_engine_if.slave  bus
);

   localparam int PW = 11 + FRAC_BITS;
   localparam int EW = PW + 2;
   localparam int IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

   localparam logic signed [EW-1:0] L_XMAX   = EW'((640 - BALL_SIZE) << FRAC_BITS);
   localparam logic signed [EW-1:0] L_YMAX   = EW'((480 - BALL_SIZE) << FRAC_BITS);
   localparam logic signed [PW-1:0] L_HOME_Y = PW'(INIT_Y0 << FRAC_BITS);
   localparam logic signed [16:0]   L_STOP   = 17'(MIN_SPEED + FRICTION);
   localparam logic signed [15:0]   L_FRIC   = 16'(FRICTION);
   localparam logic signed [16:0]   L_STEP   = 17'(SPEED_STEP);
   localparam logic signed [16:0]   L_SMAX   = 17'(MAX_SHOT_SPEED);
   localparam logic [IW-1:0]        L_LAST   = IW'(NUM_BALLS - 1);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

   function automatic logic signed [PW-1:0] f_home_x(input int i);
      return PW'((INIT_X0 + i * INIT_DX) << FRAC_BITS);
   endfunction

   function automatic logic signed [15:0] f_friction(input logic signed [15:0] v);
      logic signed [16:0] w_mag;
      w_mag = v[15] ? -17'(v) : 17'(v);
      if (w_mag <= L_STOP) return '0;
      else if (v[15])      return v + L_FRIC;
      else                 return v - L_FRIC;
   endfunction

   function automatic logic signed [15:0] f_charge(input logic signed [15:0] s, input logic up);
      logic signed [16:0] w_sum;
      w_sum = up ? (17'(s) + L_STEP) : (17'(s) - L_STEP);
      if (w_sum > L_SMAX)       return 16'(L_SMAX);
      else if (w_sum < -L_SMAX) return 16'(-L_SMAX);
      else                      return 16'(w_sum);
   endfunction

   state_t                r_state, w_state_next;
   logic [IW-1:0]         r_idx, w_idx_next;
   logic signed [15:0]    r_vx [NUM_BALLS];
   logic signed [15:0]    r_vy [NUM_BALLS];
   logic signed [PW-1:0]  r_px [NUM_BALLS];
   logic signed [PW-1:0]  r_py [NUM_BALLS];
   logic [NUM_BALLS-1:0]  r_active, r_pendL, r_pendT, r_pendR, r_pendB;
   logic                  r_respawn, r_allStopped, r_frameOverrun;
   logic signed [15:0]    r_shotX, r_shotY;

   logic                  w_busy, w_do_update, w_fire, w_all_stop;
   logic signed [15:0]    w_vxr, w_vyr, w_vx_new, w_vy_new;
   logic signed [EW-1:0]  w_pxs, w_pys;
   logic signed [PW-1:0]  w_px_new, w_py_new;

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      case (r_state)
         S_IDLE: begin
            if (bus.startOfFrame) begin
               w_state_next = S_UPDATE;
               w_idx_next   = '0;
            end
         end
         S_UPDATE: begin
            if (r_idx == L_LAST) begin
               w_state_next = S_DONE;
               w_idx_next   = '0;
            end else begin
               w_idx_next   = r_idx + IW'(1);
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Reflect, advance, clamp against the walls, then bleed off speed.
   always_comb begin
      w_vxr = r_vx[r_idx];
      w_vyr = r_vy[r_idx];
      if ((r_pendL[r_idx] && w_vxr[15]) || (r_pendR[r_idx] && !w_vxr[15] && w_vxr != '0))
         w_vxr = -w_vxr;
      if ((r_pendT[r_idx] && w_vyr[15]) || (r_pendB[r_idx] && !w_vyr[15] && w_vyr != '0))
         w_vyr = -w_vyr;
      w_pxs = EW'(r_px[r_idx]) + EW'(w_vxr);
      w_pys = EW'(r_py[r_idx]) + EW'(w_vyr);
      if (w_pxs[EW-1]) begin
         w_pxs = '0;
         w_vxr = -w_vxr;
      end else if (w_pxs > L_XMAX) begin
         w_pxs = L_XMAX;
         w_vxr = -w_vxr;
      end
      if (w_pys[EW-1]) begin
         w_pys = '0;
         w_vyr = -w_vyr;
      end else if (w_pys > L_YMAX) begin
         w_pys = L_YMAX;
         w_vyr = -w_vyr;
      end
      w_px_new = PW'(w_pxs);
      w_py_new = PW'(w_pys);
      w_vx_new = f_friction(w_vxr);
      w_vy_new = f_friction(w_vyr);
   end

   always_comb begin
      w_all_stop = 1'b1;
      for (int i = 0; i < NUM_BALLS; i++)
         if (r_active[i] && (r_vx[i] != '0 || r_vy[i] != '0)) w_all_stop = 1'b0;
   end

   assign w_busy      = (r_state != S_IDLE);
   assign w_do_update = (r_state == S_UPDATE) && r_active[r_idx] && !bus.pocketed[r_idx];
   assign w_fire      = bus.releaseBall && r_allStopped && (r_shotX != '0 || r_shotY != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_idx          <= '0;
         r_active       <= '1;
         r_pendL        <= '0;
         r_pendT        <= '0;
         r_pendR        <= '0;
         r_pendB        <= '0;
         r_respawn      <= 1'b0;
         r_allStopped   <= 1'b1;
         r_frameOverrun <= 1'b0;
         r_shotX        <= '0;
         r_shotY        <= '0;
         for (int i = 0; i < NUM_BALLS; i++) begin
            r_px[i] <= f_home_x(i);
            r_py[i] <= L_HOME_Y;
            r_vx[i] <= '0;
            r_vy[i] <= '0;
         end
      end else begin
         r_state        <= w_state_next;
         r_idx          <= w_idx_next;
         r_frameOverrun <= bus.startOfFrame && w_busy;

         if (w_do_update) begin
            if (r_idx == '0 && r_respawn) begin
               r_px[0]   <= f_home_x(0);
               r_py[0]   <= L_HOME_Y;
               r_vx[0]   <= '0;
               r_vy[0]   <= '0;
               r_respawn <= 1'b0;
            end else begin
               r_px[r_idx] <= w_px_new;
               r_py[r_idx] <= w_py_new;
               r_vx[r_idx] <= w_vx_new;
               r_vy[r_idx] <= w_vy_new;
            end
            r_pendL[r_idx] <= 1'b0;
            r_pendT[r_idx] <= 1'b0;
            r_pendR[r_idx] <= 1'b0;
            r_pendB[r_idx] <= 1'b0;
         end

         // New edge hits land after the clear so they survive a same-cycle update.
         for (int i = 0; i < NUM_BALLS; i++) begin
            if (bus.collision[i]) begin
               if (bus.hitEdgeCode[4*i+3]) r_pendL[i] <= 1'b1;
               if (bus.hitEdgeCode[4*i+2]) r_pendT[i] <= 1'b1;
               if (bus.hitEdgeCode[4*i+1]) r_pendR[i] <= 1'b1;
               if (bus.hitEdgeCode[4*i])   r_pendB[i] <= 1'b1;
            end
         end

         if (r_state == S_DONE) r_allStopped <= w_all_stop;

         if (r_allStopped) begin
            if (bus.chargeLeft != bus.chargeRight) r_shotX <= f_charge(r_shotX, bus.chargeLeft);
            if (bus.chargeUp != bus.chargeDown)    r_shotY <= f_charge(r_shotY, bus.chargeUp);
         end

         if (w_fire) begin
            r_vx[0]      <= r_shotX;
            r_vy[0]      <= r_shotY;
            r_shotX      <= '0;
            r_shotY      <= '0;
            r_allStopped <= 1'b0;
         end

         for (int i = 0; i < NUM_BALLS; i++) begin
            if (bus.pocketed[i]) begin
               r_vx[i] <= '0;
               r_vy[i] <= '0;
               if (i == 0) r_respawn   <= 1'b1;
               else        r_active[i] <= 1'b0;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_BALLS; g++) begin : g_pos
      assign bus.topLeftX[11*g +: 11] = r_px[g][PW-1 -: 11];
      assign bus.topLeftY[11*g +: 11] = r_py[g][PW-1 -: 11];
   end

   assign bus.ballActive   = r_active;
   assign bus.allStopped   = r_allStopped;
   assign bus.shotX        = r_shotX;
   assign bus.shotY        = r_shotY;
   assign bus.busy         = w_busy;
   assign bus.frameOverrun = r_frameOverrun;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine with a per-cycle reference model of the
// table (integer ball kinematics) checked against every output on each cycle.
module tb_ball_motion_engine;
   localparam int NB   = 4;
   localparam int FB   = 6;
   localparam int XMAX = (640 - 32) * 64;
   localparam int YMAX = (480 - 32) * 64;
   localparam int STOP = 3;
   localparam int STEP = 200;
   localparam int SMAX = 1000;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ball_motion_engine_if #(.NUM_BALLS(NB)) bus();
   ball_motion_engine #(.NUM_BALLS(NB)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference table: positions in 1/64 pixel, speeds in 1/64 pixel per frame.
   int m_vx[NB], m_vy[NB], m_px[NB], m_py[NB];
   bit m_act[NB], m_pl[NB], m_pt[NB], m_pr[NB], m_pb[NB];
   bit m_resp, m_as, m_ov, m_valid = 0;
   int m_sx, m_sy;
   int m_pos;   // ball handled at the coming edge; -1 idle, NB = wrap-up cycle

   function automatic int fric(input int v);
      if (v <= STOP && v >= -STOP) return 0;
      return (v < 0) ? v + 1 : v - 1;
   endfunction

   function automatic int sat(input int v);
      if (v > SMAX) return SMAX;
      if (v < -SMAX) return -SMAX;
      return v;
   endfunction

   task automatic model_home(input int k);
      m_px[k] = (100 + 40 * k) * 64;
      m_py[k] = 220 * 64;
      m_vx[k] = 0;
      m_vy[k] = 0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < NB; k++) begin
         model_home(k);
         m_act[k] = 1; m_pl[k] = 0; m_pt[k] = 0; m_pr[k] = 0; m_pb[k] = 0;
      end
      m_resp = 0; m_as = 1; m_ov = 0; m_sx = 0; m_sy = 0; m_pos = -1;
   endtask

   task automatic ball_frame(input int k);
      int vx, vy;
      if (k == 0 && m_resp) begin
         model_home(0);
         m_resp = 0;
      end else begin
         vx = m_vx[k];
         vy = m_vy[k];
         if ((m_pl[k] && vx < 0) || (m_pr[k] && vx > 0)) vx = -vx;
         if ((m_pt[k] && vy < 0) || (m_pb[k] && vy > 0)) vy = -vy;
         m_px[k] += vx;
         m_py[k] += vy;
         if (m_px[k] < 0) begin m_px[k] = 0; vx = -vx; end
         else if (m_px[k] > XMAX) begin m_px[k] = XMAX; vx = -vx; end
         if (m_py[k] < 0) begin m_py[k] = 0; vy = -vy; end
         else if (m_py[k] > YMAX) begin m_py[k] = YMAX; vy = -vy; end
         m_vx[k] = fric(vx);
         m_vy[k] = fric(vy);
      end
      m_pl[k] = 0; m_pt[k] = 0; m_pr[k] = 0; m_pb[k] = 0;
   endtask

   task automatic model_step();
      bit busy_old, as_old;
      busy_old = (m_pos != -1);
      as_old   = m_as;
      m_ov     = bus.startOfFrame && busy_old;
      if (m_pos == NB) begin
         m_as = 1;
         for (int k = 0; k < NB; k++)
            if (m_act[k] && (m_vx[k] != 0 || m_vy[k] != 0)) m_as = 0;
      end
      if (m_pos >= 0 && m_pos < NB)
         if (m_act[m_pos] && !bus.pocketed[m_pos]) ball_frame(m_pos);
      for (int k = 0; k < NB; k++)
         if (bus.collision[k]) begin
            if (bus.hitEdgeCode[4*k+3]) m_pl[k] = 1;
            if (bus.hitEdgeCode[4*k+2]) m_pt[k] = 1;
            if (bus.hitEdgeCode[4*k+1]) m_pr[k] = 1;
            if (bus.hitEdgeCode[4*k])   m_pb[k] = 1;
         end
      if (as_old) begin
         if (bus.chargeLeft && !bus.chargeRight) m_sx = sat(m_sx + STEP);
         if (bus.chargeRight && !bus.chargeLeft) m_sx = sat(m_sx - STEP);
         if (bus.chargeUp && !bus.chargeDown)    m_sy = sat(m_sy + STEP);
         if (bus.chargeDown && !bus.chargeUp)    m_sy = sat(m_sy - STEP);
      end
      if (bus.releaseBall && as_old && (m_sx != 0 || m_sy != 0)) begin
         m_vx[0] = m_sx; m_vy[0] = m_sy;
         m_sx = 0; m_sy = 0; m_as = 0;
      end
      for (int k = 0; k < NB; k++)
         if (bus.pocketed[k]) begin
            m_vx[k] = 0; m_vy[k] = 0;
            if (k == 0) m_resp = 1;
            else        m_act[k] = 0;
         end
      if (m_pos == -1) begin
         if (bus.startOfFrame) m_pos = 0;
      end else if (m_pos == NB) m_pos = -1;
      else m_pos++;
   endtask

   always @(posedge clk) begin
      if (reset) begin
         model_reset();
         m_valid = 1;
      end else if (m_valid) begin
         model_step();
      end
   end

   function automatic int tlx(input int k);
      return int'($signed(bus.topLeftX[11*k +: 11]));
   endfunction
   function automatic int tly(input int k);
      return int'($signed(bus.topLeftY[11*k +: 11]));
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         int actv;
         actv = 0;
         for (int k = 0; k < NB; k++) begin
            check($sformatf("tlx%0d", k), tlx(k), m_px[k] >>> FB);
            check($sformatf("tly%0d", k), tly(k), m_py[k] >>> FB);
            if (m_act[k]) actv |= (1 << k);
         end
         check("ballActive", int'(bus.ballActive), actv);
         check("allStopped", int'(bus.allStopped), int'(m_as));
         check("shotX", int'(bus.shotX), m_sx);
         check("shotY", int'(bus.shotY), m_sy);
         check("busy", int'(bus.busy), int'(m_pos != -1));
         check("frameOverrun", int'(bus.frameOverrun), int'(m_ov));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_frame(input bit mid, input logic [3:0] code);
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      if (mid) begin
         bus.collision[0]      = 1'b1;
         bus.hitEdgeCode[3:0]  = code;
      end
      tick();
      bus.collision   = '0;
      bus.hitEdgeCode = '0;
      repeat (NB) tick();
   endtask

   task automatic run_until_stopped(input int maxf, input string name);
      int r;
      for (int f = 0; f < maxf; f++) begin
         if (bus.allStopped) break;
         r = $urandom_range(0, 7);
         if (r == 0) begin
            bus.collision[0]     = 1'b1;
            bus.hitEdgeCode[3:0] = 4'($urandom_range(0, 15));
            tick();
            bus.collision   = '0;
            bus.hitEdgeCode = '0;
         end
         do_frame(r == 1, 4'($urandom_range(0, 15)));
      end
      check(name, int'(bus.allStopped), 1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      int exp_x[6];
      exp_x = '{200, 400, 600, 800, 1000, 1000};
      bus.startOfFrame = 0; bus.chargeUp = 0; bus.chargeDown = 0;
      bus.chargeLeft = 0; bus.chargeRight = 0; bus.releaseBall = 0;
      bus.collision = '0; bus.hitEdgeCode = '0; bus.pocketed = '0;
      tick(); tick();
      reset = 1'b0;

      check("rst_active", int'(bus.ballActive), 15);
      check("rst_allStopped", int'(bus.allStopped), 1);
      check("rst_shotX", int'(bus.shotX), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_tlx3", tlx(3), 220);
      check("rst_tly0", tly(0), 220);

      for (int k = 0; k < 6; k++) begin
         bus.chargeLeft = 1; tick(); bus.chargeLeft = 0;
         check($sformatf("charge_left%0d", k), int'(bus.shotX), exp_x[k]);
      end
      bus.chargeLeft = 1; bus.chargeRight = 1; tick();
      bus.chargeLeft = 0; bus.chargeRight = 0;
      check("charge_opposed", int'(bus.shotX), 1000);
      repeat (3) begin bus.chargeRight = 1; tick(); bus.chargeRight = 0; end
      check("charge_right3", int'(bus.shotX), 400);
      bus.chargeUp = 1; tick(); bus.chargeUp = 0;
      check("charge_up", int'(bus.shotY), 200);
      bus.chargeDown = 1; tick(); bus.chargeDown = 0;
      check("charge_down", int'(bus.shotY), 0);

      bus.releaseBall = 1; tick(); bus.releaseBall = 0;
      check("release_shotX", int'(bus.shotX), 0);
      check("release_allStopped", int'(bus.allStopped), 0);
      do_frame(0, 4'h0);
      check("frame1_tlx0", tlx(0), 106);
      check("frame1_model_px0", m_px[0], 6800);
      check("frame1_model_vx0", m_vx[0], 399);
      check("frame1_allStopped", int'(bus.allStopped), 0);
      bus.chargeLeft = 1; tick(); bus.chargeLeft = 0;
      check("charge_while_moving", int'(bus.shotX), 0);
      do_frame(0, 4'h0);
      check("frame2_tlx0", tlx(0), 112);

      bus.pocketed = 4'b0001; tick(); bus.pocketed = '0;
      do_frame(0, 4'h0);
      check("respawn_tlx0", tlx(0), 100);
      check("respawn_tly0", tly(0), 220);
      check("respawn_model_vx0", m_vx[0], 0);
      check("respawn_allStopped", int'(bus.allStopped), 1);

      bus.chargeRight = 1; tick(); bus.chargeRight = 0;
      check("shot_neg", int'(bus.shotX), -200);
      bus.releaseBall = 1; tick(); bus.releaseBall = 0;
      bus.collision = 4'b0001; bus.hitEdgeCode = 16'h0008; tick();
      bus.collision = '0; bus.hitEdgeCode = '0;
      do_frame(0, 4'h0);
      check("reflect_tlx0", tlx(0), 103);
      check("reflect_model_vx0", m_vx[0], 199);
      bus.pocketed = 4'b0001; tick(); bus.pocketed = '0;
      do_frame(0, 4'h0);
      check("stop_by_pocket", int'(bus.allStopped), 1);

      bus.chargeLeft = 1; bus.chargeUp = 1; tick();
      bus.chargeLeft = 0; bus.chargeUp = 0;
      bus.releaseBall = 1; tick(); bus.releaseBall = 0;
      run_until_stopped(600, "run1_stopped");
      bus.chargeLeft = 1; tick(); bus.chargeLeft = 0;
      check("charge_after_stop", int'(bus.shotX), 200);
      repeat (6) begin bus.chargeRight = 1; tick(); bus.chargeRight = 0; end
      check("charge_neg_sat", int'(bus.shotX), -1000);
      bus.releaseBall = 1; tick(); bus.releaseBall = 0;
      run_until_stopped(1500, "run2_stopped");

      bus.pocketed = 4'b0100; tick(); bus.pocketed = '0;
      check("pocket2_active", int'(bus.ballActive), 11);
      bus.collision = 4'b0100; bus.hitEdgeCode = 16'h0F00; tick();
      bus.collision = '0; bus.hitEdgeCode = '0;
      do_frame(0, 4'h0);
      check("pocket2_frozen_x", tlx(2), 180);
      check("pocket2_frozen_y", tly(2), 220);

      bus.chargeLeft = 1; tick(); bus.chargeLeft = 0;
      bus.releaseBall = 1; tick(); bus.releaseBall = 0;
      bus.startOfFrame = 1; tick(); bus.startOfFrame = 0;
      bus.startOfFrame = 1; tick(); bus.startOfFrame = 0;
      check("overrun_pulse", int'(bus.frameOverrun), 1);
      tick();
      check("overrun_clear", int'(bus.frameOverrun), 0);
      tick(); tick();
      check("overrun_still_busy", int'(bus.busy), 1);
      tick();
      check("overrun_no_restart", int'(bus.busy), 0);

      bus.startOfFrame = 1; tick(); bus.startOfFrame = 0;
      tick(); tick();
      check("midframe_busy", int'(bus.busy), 1);
      reset = 1'b1; tick(); reset = 1'b0;
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_tlx0", tlx(0), 100);
      check("midrst_tlx2", tlx(2), 180);
      check("midrst_active", int'(bus.ballActive), 15);
      check("midrst_allStopped", int'(bus.allStopped), 1);
      do_frame(0, 4'h0);
      check("post_rst_idle", int'(bus.busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
